// File: rtl/store_unit.sv
// store_unit: memory-write side of the MIPS datapath.
// Computes the effective address of SB/SH/SW, formats byte-lane write data
// and byte enables, and runs a req/ack handshake with data memory, reporting
// done, misaligned-address and timeout status back to control.
module store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          BIG_ENDIAN     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] base,
    input  logic [31:0] store_data,
    input  logic [15:0] offset,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          misalign_q,  misalign_d;
    logic          timeout_q,   timeout_d;
    logic          mem_req_q,   mem_req_d;
    logic [31:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q,    mem_be_d;
    logic [CW-1:0] cnt_q,       cnt_d;

    logic [31:0]   ea;
    logic [1:0]    lane;
    logic          op_valid;
    logic          addr_bad;
    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_be;
    logic [CW-1:0] cnt_inc;

    // Effective address, lane selection and per-opcode data/enable formatting.
    // For 2-bit values 3-x equals ~x, so big-endian lane mapping is an XOR.
    always_comb begin
        ea        = base + {{16{offset[15]}}, offset};
        lane      = ea[1:0] ^ {2{BIG_ENDIAN}};
        op_valid  = 1'b0;
        addr_bad  = 1'b0;
        fmt_wdata = '0;
        fmt_be    = '0;
        case (opcode)
            OP_SB: begin
                op_valid  = 1'b1;
                fmt_wdata = {4{store_data[7:0]}};
                fmt_be    = 4'b0001 << lane;
            end
            OP_SH: begin
                op_valid  = 1'b1;
                addr_bad  = ea[0];
                fmt_wdata = {2{store_data[15:0]}};
                fmt_be    = 4'b0011 << {lane[1], 1'b0};
            end
            OP_SW: begin
                op_valid  = 1'b1;
                addr_bad  = |ea[1:0];
                fmt_wdata = store_data;
                fmt_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/REQ/DONE handshake.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && op_valid) begin
                    mem_addr_d  = {ea[31:2], 2'b00};
                    mem_wdata_d = fmt_wdata;
                    mem_be_d    = fmt_be;
                    busy_d      = 1'b1;
                    if (addr_bad) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d   = S_REQ;
                        mem_req_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                // An ack on the last allowed cycle takes priority over timeout.
                if (mem_ack) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                end else if (cnt_inc >= CW'(TIMEOUT_CYCLES)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    mem_req_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                cnt_d     = '0;
            end
            default: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign timeout   = timeout_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed testbench for store_unit with a scoreboard of expected stores.
module tb_store_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] base;
    logic [31:0] store_data;
    logic [15:0] offset;
    logic        busy;
    logic        done;
    logic        misalign;
    logic        timeout;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        mis;
        logic        tmo;
        int          req;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   req_cycles;
    int   done_cnt;

    store_unit #(.TIMEOUT_CYCLES(16), .BIG_ENDIAN(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .base      (base),
        .store_data(store_data),
        .offset    (offset),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .timeout   (timeout),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference model of one store.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] b,
                                   input logic [15:0] off, input logic [31:0] d, input int req);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] sext;
        sext = {{16{off[15]}}, off};
        a = b + sext;
        e.addr = {a[31:2], 2'b00};
        e.tmo  = 1'b0;
        e.req  = req;
        e.mis  = 1'b0;
        e.be   = 4'b0000;
        e.wdata = 32'h0;
        if (op == 6'h28) begin
            e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
            case (a[1:0])
                2'd0: e.be = 4'b0001;
                2'd1: e.be = 4'b0010;
                2'd2: e.be = 4'b0100;
                default: e.be = 4'b1000;
            endcase
        end else if (op == 6'h29) begin
            e.wdata = {d[15:0], d[15:0]};
            e.be    = a[1] ? 4'b1100 : 4'b0011;
            e.mis   = a[0];
        end else begin
            e.wdata = d;
            e.be    = 4'b1111;
            e.mis   = (a[1:0] != 2'b00);
        end
        return e;
    endfunction

    // Advance one clock, then check outputs against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (mem_req === 1'b1) begin
            req_cycles++;
            chk("req_has_sb", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("mem_addr",  mem_addr,  sb[0].addr);
                chk("mem_wdata", mem_wdata, sb[0].wdata);
                chk("mem_be",    32'(mem_be), 32'(sb[0].be));
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_has_sb", 32'(sb.size() != 0), 32'd1);
            chk("done_no_req", 32'(mem_req), 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("misalign",   32'(misalign), 32'(e.mis));
                chk("timeout",    32'(timeout),  32'(e.tmo));
                chk("req_cycles", 32'(req_cycles), 32'(e.req));
            end
            req_cycles = 0;
        end else begin
            chk("flags_quiet", 32'({misalign, timeout}), 32'd0);
        end
    endtask

    // Drive one start pulse and push the expected result.
    task automatic issue(input logic [5:0] op, input logic [31:0] b, input logic [15:0] off,
                         input logic [31:0] d, input int req, input logic tmo);
        exp_t e;
        e = model(op, b, off, d, req);
        e.tmo = tmo;
        sb.push_back(e);
        opcode = op; base = b; offset = off; store_data = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        n_tests = 0; n_fail = 0; req_cycles = 0; done_cnt = 0;
        rst_n = 1'b0; start = 1'b0; opcode = 6'h0; base = '0; store_data = '0;
        offset = '0; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Reset state.
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be",    32'(mem_be), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: SB at EA 0x103, ack in the first request cycle.
        issue(6'h28, 32'h100, 16'd3, 32'h12345678, 1, 1'b0);
        chk("t1_req",  32'(mem_req), 32'd1);
        chk("t1_be",   32'(mem_be), 32'h8);
        chk("t1_busy", 32'(busy), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t1_done", 32'(done), 32'd1);
        tick();
        chk("t1_done_once", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: SH with negative offset, EA 0x1FE, ack in the second request cycle.
        issue(6'h29, 32'h200, 16'hFFFE, 32'h12345678, 2, 1'b0);
        chk("t2_addr", mem_addr, 32'h1FC);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t2_done", 32'(done), 32'd1);
        tick();

        // 3: misaligned SW, done one cycle after start, no request.
        issue(6'h2B, 32'h100, 16'd2, 32'hCAFEF00D, 0, 1'b0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_mis",  32'(misalign), 32'd1);
        chk("t3_req",  32'(mem_req), 32'd0);
        tick();

        // 4: SW with no ack, must time out after 16 request cycles.
        issue(6'h2B, 32'h40, 16'd0, 32'hA5A5A5A5, 16, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t4_latency", 32'(n), 32'd16);
        chk("t4_timeout", 32'(timeout), 32'd1);
        tick();

        // 4b: ack in the final allowed cycle beats the timeout.
        issue(6'h2B, 32'h80, 16'd4, 32'h0BADBEEF, 16, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk("t4b_req16", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t4b_done", 32'(done), 32'd1);
        chk("t4b_tmo",  32'(timeout), 32'd0);
        tick();

        // 5: reset in the third request cycle abandons the store.
        issue(6'h2B, 32'h300, 16'd0, 32'h11112222, 3, 1'b0);
        tick();
        tick();
        chk("t5_req3", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        void'(sb.pop_front());
        tick();
        chk("t5_req0",  32'(mem_req), 32'd0);
        chk("t5_busy0", 32'(busy), 32'd0);
        chk("t5_done0", 32'(done), 32'd0);
        req_cycles = 0;
        rst_n = 1'b1;
        tick();
        issue(6'h2B, 32'h304, 16'd0, 32'h33334444, 1, 1'b0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t5_new_done", 32'(done), 32'd1);
        tick();

        // 6: start while busy and invalid opcode are ignored; stray acks too.
        n = done_cnt;
        issue(6'h2B, 32'h400, 16'd8, 32'h55667788, 2, 1'b0);
        opcode = 6'h28; base = 32'h500; offset = 16'd1; start = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t6_done", 32'(done), 32'd1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        opcode = 6'h24; base = 32'h600; offset = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_idle_req",  32'(mem_req), 32'd0);
        chk("t6_one_done",  32'(done_cnt - n), 32'd1);
        chk("t6_sb_empty",  32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
